status_buffer_px: RTL and testbench
===================================

Name: status_buffer_px

Overview:
- Parametrised successor to the fixed 4x2-bit status memory used in the Basic CAN message-buffer logic.
- Stores DEPTH status descriptors of DSC_W bits, with one write port and one combinational read port.
- Write port supports four bit-wise modes: load, set, clear and toggle.
- Each entry has an "updated" flag that is set on a value change and cleared by a host acknowledge. A registered priority scan tells the CPU-interface/IRQ logic the lowest-index pending entry and the pending count.

Parameters:
- DSC_W, 2, descriptor width in bits (1..16).
- DEPTH, 4, number of entries (2..32; need not be a power of two).
- AW, 2, pointer width; must satisfy 2**AW >= DEPTH.
- CW, 3, pending-count width; must satisfy 2**CW > DEPTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rsn  in  1  reset, synchronous, active-low; sampled on the rising clk edge.
- dsc_in  in  DSC_W  write data / bit mask.
- b_ptr  in  AW  write address.
- wrn  in  1  write strobe, active-low.
- wr_mode  in  2  write mode: 00 load, 01 set (OR), 10 clear (AND-NOT), 11 toggle (XOR).
- a_ptr  in  AW  read address.
- ackn  in  1  acknowledge, active-low; clears the updated flag of entry a_ptr.
- dsc_out  out  DSC_W  stored descriptor of entry a_ptr (combinational).
- upd_out  out  1  updated flag of entry a_ptr (combinational).
- pend_any  out  1  registered: at least one flag is set.
- pend_ptr  out  AW  registered: lowest index with its flag set; 0 when none.
- pend_cnt  out  CW  registered: number of flags set.
- par_err  out  1  parity error on the read entry (see Optional Feature).

Behaviour:
- Reset (rsn=0 at a rising edge): all entries 0, all flags 0, pend_any=0, pend_ptr=0, pend_cnt=0, sticky parity state 0. Reset overrides any write or ack in the same cycle.
- Write: when wrn=0 and b_ptr<DEPTH, at the edge new = f(old, dsc_in, wr_mode):
  - 00: new = dsc_in
  - 01: new = old | dsc_in
  - 10: new = old & ~dsc_in
  - 11: new = old ^ dsc_in
- Flag set: the entry's flag is set only if new != old. A write that leaves the value unchanged does not set the flag.
- Out-of-range pointers:
  - b_ptr >= DEPTH: write ignored.
  - a_ptr >= DEPTH: dsc_out=0, upd_out=0, and ackn is ignored.
- Read is combinational. A value written at edge N appears on dsc_out/upd_out immediately after edge N (no read-during-write bypass before the edge).
- Ack: when ackn=0 and a_ptr<DEPTH, the flag of entry a_ptr is cleared at the edge.
- Same entry written (with a value change) and acked in the same cycle: write wins, flag ends set.
- Pending outputs are registered from the flag vector as it stands before each edge. A flag changing at edge N is reflected in pend_* after edge N+1 (one-cycle latency).
- pend_cnt is recomputed as a population count each cycle, not incremented/decremented, so simultaneous set/clear on different entries is always exact.
- pend_ptr is the lowest-set-index priority. It holds 0 when pend_any=0.

Optional Feature:
- Macro: STATUS_BUFFER_PARITY_EN.
- Enabled:
  - Each entry stores an extra even-parity bit computed from new on every write and reset to 0.
  - par_err is combinational: (a_ptr<DEPTH) and (parity of stored data != stored parity bit).
  - A sticky internal flag latches any par_err=1 and is ORed onto par_err; only rsn clears it.
- Disabled: no parity storage, par_err tied to 0.

Decomposition:
- Package status_buffer_pkg holds the wr_mode encodings (WM_LOAD=2'b00, WM_SET=2'b01, WM_CLR=2'b10, WM_TGL=2'b11) and a function computing new from (old, mask, mode).
- One sub-module, status_pend_scan: combinational DEPTH-wide lowest-index priority encoder plus population count. The top-level module registers its outputs.

Test Plan:
- Reset then idle: every a_ptr gives dsc_out=0, upd_out=0; pend_any=0, pend_cnt=0, pend_ptr=0.
- Load 2'b10 to entry 2 (DEFAULT params): dsc_out(a_ptr=2)=2'b10 after the edge and upd_out=1; one cycle later pend_any=1, pend_ptr=2, pend_cnt=1. Ack entry 2: pend_any=0 two edges later.
- Modes on entry 1 starting at 2'b01: set with 2'b10 gives 2'b11; clear with 2'b01 gives 2'b10; toggle with 2'b11 gives 2'b01. Each sets the flag. A set with 2'b01 on 2'b01 (unchanged) leaves an acked flag clear.
- Flags pending on entries 3 and 1: pend_ptr=1, pend_cnt=2. Ack entry 1 and write-change entry 0 in the same cycle: pend_ptr=0, pend_cnt=2. Write-change entry 3 with ack of entry 3: flag stays 1.
- DEPTH=5, AW=3, CW=3: write to b_ptr=6 is ignored (all entries unchanged); a_ptr=7 reads 0. Set all 5 flags: pend_cnt=5.
- Parity build: force a stored parity bit mismatch on entry 0 and read it: par_err=1 and it stays 1 after a_ptr moves away, until rsn=0. Non-parity build: par_err=0 throughout.

Source files
------------

// File: rtl/status_buffer_pkg.sv
// Shared write-mode encodings and the bit-wise update function
// for the status descriptor buffer.
package status_buffer_pkg;

  localparam int MAX_W = 16;

  localparam logic [1:0] WM_LOAD = 2'b00;
  localparam logic [1:0] WM_SET  = 2'b01;
  localparam logic [1:0] WM_CLR  = 2'b10;
  localparam logic [1:0] WM_TGL  = 2'b11;

  function automatic logic [MAX_W-1:0] wr_apply(
    input logic [MAX_W-1:0] old,
    input logic [MAX_W-1:0] mask,
    input logic [1:0]       mode
  );
    logic [MAX_W-1:0] res;
    unique case (mode)
      WM_LOAD: res = mask;
      WM_SET:  res = old | mask;
      WM_CLR:  res = old & ~mask;
      WM_TGL:  res = old ^ mask;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/status_pend_scan.sv
// Lowest-index priority encoder and population count over the
// per-entry updated flags; purely combinational.
module status_pend_scan
  import status_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CW    = 3
) (
  input  logic [DEPTH-1:0] i_flags,
  output logic             o_any,
  output logic [AW-1:0]    o_ptr,
  output logic [CW-1:0]    o_cnt
);

  assign o_any = |i_flags;

  // Scan from the top down so the lowest set index wins.
  always_comb begin
    o_ptr = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i_flags[i]) o_ptr = AW'(i);
    end
  end

  // Full recount every cycle keeps concurrent set/clear exact.
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_cnt = o_cnt + CW'(i_flags[i]);
    end
  end

endmodule

// File: rtl/status_buffer_px.sv
// Parametrised status descriptor buffer with updated flags and a
// registered pending scan. Optional parity: STATUS_BUFFER_PARITY_EN.
module status_buffer_px
  import status_buffer_pkg::*;
#(
  parameter int DSC_W = 2,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rsn,
  input  logic [DSC_W-1:0] dsc_in,
  input  logic [AW-1:0]    b_ptr,
  input  logic             wrn,
  input  logic [1:0]       wr_mode,
  input  logic [AW-1:0]    a_ptr,
  input  logic             ackn,
  output logic [DSC_W-1:0] dsc_out,
  output logic             upd_out,
  output logic             pend_any,
  output logic [AW-1:0]    pend_ptr,
  output logic [CW-1:0]    pend_cnt,
  output logic             par_err
);

  logic [DSC_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_upd;
  logic             r_pend_any;
  logic [AW-1:0]    r_pend_ptr;
  logic [CW-1:0]    r_pend_cnt;

  logic             w_b_ok;
  logic             w_a_ok;
  logic             w_wr;
  logic             w_ack;
  logic             w_chg;
  logic [DSC_W-1:0] w_old;
  logic [DSC_W-1:0] w_new;
  logic             w_any;
  logic [AW-1:0]    w_ptr;
  logic [CW-1:0]    w_cnt;

  assign w_b_ok = int'(b_ptr) < DEPTH;
  assign w_a_ok = int'(a_ptr) < DEPTH;
  assign w_wr   = !wrn && w_b_ok;
  assign w_ack  = !ackn && w_a_ok;

  assign w_old = w_b_ok ? r_mem[b_ptr] : '0;
  assign w_new = DSC_W'(wr_apply(MAX_W'(w_old),
                                 MAX_W'(dsc_in),
                                 wr_mode));
  assign w_chg = w_new != w_old;

  assign dsc_out = w_a_ok ? r_mem[a_ptr] : '0;
  assign upd_out = w_a_ok && r_upd[a_ptr];

  // Descriptor storage and flags; write is applied after ack so
  // a changing write to the acked entry leaves its flag set.
  always_ff @(posedge clk) begin
    if (!rsn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_upd <= '0;
    end else begin
      if (w_ack) r_upd[a_ptr] <= 1'b0;
      if (w_wr) begin
        r_mem[b_ptr] <= w_new;
        if (w_chg) r_upd[b_ptr] <= 1'b1;
      end
    end
  end

  status_pend_scan #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .CW    (CW)
  ) u_scan (
    .i_flags (r_upd),
    .o_any   (w_any),
    .o_ptr   (w_ptr),
    .o_cnt   (w_cnt)
  );

  // Register the scan of the pre-edge flag vector.
  always_ff @(posedge clk) begin
    if (!rsn) begin
      r_pend_any <= 1'b0;
      r_pend_ptr <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_pend_any <= w_any;
      r_pend_ptr <= w_ptr;
      r_pend_cnt <= w_cnt;
    end
  end

  assign pend_any = r_pend_any;
  assign pend_ptr = r_pend_ptr;
  assign pend_cnt = r_pend_cnt;

`ifdef STATUS_BUFFER_PARITY_EN
  logic [DEPTH-1:0] r_par;
  logic             r_perr_stk;
  logic             w_perr_raw;

  assign w_perr_raw = w_a_ok &&
                      ((^r_mem[a_ptr]) != r_par[a_ptr]);
  assign par_err    = w_perr_raw || r_perr_stk;

  // Even parity of the value written, kept alongside each entry.
  always_ff @(posedge clk) begin
    if (!rsn) begin
      r_par <= '0;
    end else if (w_wr) begin
      r_par[b_ptr] <= ^w_new;
    end
  end

  // Sticky error latch; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rsn) begin
      r_perr_stk <= 1'b0;
    end else if (w_perr_raw) begin
      r_perr_stk <= 1'b1;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_status_buffer_px.sv
// Bench for status_buffer_px: directed table, random run against a
// reference model, and a DEPTH=5 instance for range corners.
module tb_status_buffer_px;

  logic       clk = 1'b0;
  logic       rsn, wrn, ackn;
  logic [1:0] dsc_in, b_ptr, a_ptr, wr_mode;
  logic [1:0] dsc_out;
  logic       upd_out, pend_any, par_err;
  logic [1:0] pend_ptr;
  logic [2:0] pend_cnt;

  logic       rsn5, wrn5, ackn5;
  logic [1:0] dsc_in5, wr_mode5, dsc_out5;
  logic [2:0] b_ptr5, a_ptr5, pend_ptr5, pend_cnt5;
  logic       upd_out5, pend_any5, par_err5;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  status_buffer_px dut (
    .clk(clk), .rsn(rsn), .dsc_in(dsc_in), .b_ptr(b_ptr),
    .wrn(wrn), .wr_mode(wr_mode), .a_ptr(a_ptr), .ackn(ackn),
    .dsc_out(dsc_out), .upd_out(upd_out), .pend_any(pend_any),
    .pend_ptr(pend_ptr), .pend_cnt(pend_cnt), .par_err(par_err)
  );

  status_buffer_px #(.DSC_W(2), .DEPTH(5), .AW(3), .CW(3)) dut5 (
    .clk(clk), .rsn(rsn5), .dsc_in(dsc_in5), .b_ptr(b_ptr5),
    .wrn(wrn5), .wr_mode(wr_mode5), .a_ptr(a_ptr5), .ackn(ackn5),
    .dsc_out(dsc_out5), .upd_out(upd_out5), .pend_any(pend_any5),
    .pend_ptr(pend_ptr5), .pend_cnt(pend_cnt5), .par_err(par_err5)
  );

  // Reference model: plain arrays of values and flags.
  int m_mem [4];
  bit m_upd [4];
  int e_any, e_ptr, e_cnt;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int apply(input int old, input int m,
                               input int md);
    case (md)
      0:       return m;
      1:       return old | m;
      2:       return old & ~m & 3;
      default: return old ^ m;
    endcase
  endfunction

  // Advance model and DUT by one edge; pend expectations come from
  // the flags as they stood before the edge.
  task automatic cyc();
    bit prev [4];
    int nv;
    prev = m_upd;
    if (!rsn) begin
      for (int i = 0; i < 4; i++) begin
        m_mem[i] = 0;
        m_upd[i] = 0;
      end
    end else begin
      if (!ackn) m_upd[a_ptr] = 0;
      if (!wrn) begin
        nv = apply(m_mem[b_ptr], dsc_in, wr_mode);
        if (nv != m_mem[b_ptr]) m_upd[b_ptr] = 1;
        m_mem[b_ptr] = nv;
      end
    end
    e_any = 0; e_ptr = 0; e_cnt = 0;
    if (rsn) begin
      for (int i = 0; i < 4; i++) begin
        if (prev[i]) begin
          if (e_any == 0) e_ptr = i;
          e_any = 1;
          e_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc5();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit       rsn, wrn;
    bit [1:0] b, md, d;
    bit       ackn;
    bit [1:0] a;
    int       ed, eu, ea, ep, ec;
  } vec_t;

  vec_t tbl [21];

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_mem[i] = 0;
      m_upd[i] = 0;
    end
    // rsn wrn b md d ackn a | dsc upd any ptr cnt
    tbl[0]  = '{0,1,0,0,0,1,0, 0,0,0,0,0};
    tbl[1]  = '{1,1,0,0,0,1,2, 0,0,0,0,0};
    tbl[2]  = '{1,0,2,0,2,1,2, 2,1,0,0,0};
    tbl[3]  = '{1,1,0,0,0,1,2, 2,1,1,2,1};
    tbl[4]  = '{1,1,0,0,0,0,2, 2,0,1,2,1};
    tbl[5]  = '{1,1,0,0,0,1,2, 2,0,0,0,0};
    tbl[6]  = '{1,0,1,0,1,1,1, 1,1,0,0,0};
    tbl[7]  = '{1,1,0,0,0,0,1, 1,0,1,1,1};
    tbl[8]  = '{1,0,1,1,2,1,1, 3,1,0,0,0};
    tbl[9]  = '{1,0,1,2,1,0,1, 2,1,1,1,1};
    tbl[10] = '{1,0,1,3,3,0,1, 1,1,1,1,1};
    tbl[11] = '{1,1,0,0,0,0,1, 1,0,1,1,1};
    tbl[12] = '{1,0,1,1,1,1,1, 1,0,0,0,0};
    tbl[13] = '{1,1,0,0,0,1,1, 1,0,0,0,0};
    tbl[14] = '{1,0,3,0,3,1,3, 3,1,0,0,0};
    tbl[15] = '{1,0,1,0,2,1,1, 2,1,1,3,1};
    tbl[16] = '{1,1,0,0,0,1,1, 2,1,1,1,2};
    tbl[17] = '{1,0,0,0,1,0,1, 2,0,1,1,2};
    tbl[18] = '{1,1,0,0,0,1,0, 1,1,1,0,2};
    tbl[19] = '{1,0,3,0,0,0,3, 0,1,1,0,2};
    tbl[20] = '{1,1,0,0,0,1,3, 0,1,1,0,2};

    rsn = 0; wrn = 1; ackn = 1;
    dsc_in = 0; b_ptr = 0; a_ptr = 0; wr_mode = 0;
    rsn5 = 0; wrn5 = 1; ackn5 = 1;
    dsc_in5 = 0; b_ptr5 = 0; a_ptr5 = 0; wr_mode5 = 0;

    for (int i = 0; i < 21; i++) begin
      rsn = tbl[i].rsn; wrn = tbl[i].wrn; b_ptr = tbl[i].b;
      wr_mode = tbl[i].md; dsc_in = tbl[i].d;
      ackn = tbl[i].ackn; a_ptr = tbl[i].a;
      cyc();
      chk($sformatf("t%0d dsc", i), dsc_out, tbl[i].ed);
      chk($sformatf("t%0d upd", i), upd_out, tbl[i].eu);
      chk($sformatf("t%0d any", i), pend_any, tbl[i].ea);
      chk($sformatf("t%0d ptr", i), pend_ptr, tbl[i].ep);
      chk($sformatf("t%0d cnt", i), pend_cnt, tbl[i].ec);
    end

    // Idle reads over all pointers right after reset.
    rsn = 0; wrn = 1; ackn = 1;
    cyc();
    rsn = 1;
    for (int a = 0; a < 4; a++) begin
      a_ptr = 2'(a);
      #1;
      chk($sformatf("rst dsc%0d", a), dsc_out, 0);
      chk($sformatf("rst upd%0d", a), upd_out, 0);
    end

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rsn = ($urandom_range(0, 49) != 0);
      wrn = $urandom_range(0, 1);
      ackn = ($urandom_range(0, 9) > 2);
      b_ptr = 2'($urandom_range(0, 3));
      a_ptr = 2'($urandom_range(0, 3));
      wr_mode = 2'($urandom_range(0, 3));
      dsc_in = 2'($urandom_range(0, 3));
      cyc();
      chk("rnd dsc", dsc_out, m_mem[a_ptr]);
      chk("rnd upd", upd_out, m_upd[a_ptr]);
      chk("rnd any", pend_any, e_any);
      chk("rnd ptr", pend_ptr, e_ptr);
      chk("rnd cnt", pend_cnt, e_cnt);
      chk("rnd perr", par_err, 0);
    end

    // DEPTH=5 instance: fill, ignored write, out-of-range read/ack.
    rsn5 = 0;
    cyc5();
    rsn5 = 1;
    wr_mode5 = 2'b00;
    dsc_in5 = 2'b01;
    for (int i = 0; i < 5; i++) begin
      wrn5 = 0; b_ptr5 = 3'(i);
      cyc5();
    end
    wrn5 = 0; b_ptr5 = 3'd6; dsc_in5 = 2'b11;
    cyc5();
    wrn5 = 1;
    chk("d5 any", pend_any5, 1);
    chk("d5 ptr", pend_ptr5, 0);
    chk("d5 cnt5", pend_cnt5, 5);
    for (int i = 0; i < 5; i++) begin
      a_ptr5 = 3'(i);
      #1;
      chk($sformatf("d5 dsc%0d", i), dsc_out5, 1);
      chk($sformatf("d5 upd%0d", i), upd_out5, 1);
    end
    a_ptr5 = 3'd7;
    #1;
    chk("d5 dsc7", dsc_out5, 0);
    chk("d5 upd7", upd_out5, 0);
    ackn5 = 0;
    cyc5();
    ackn5 = 1;
    cyc5();
    chk("d5 oor ack", pend_cnt5, 5);
    a_ptr5 = 3'd0;
    ackn5 = 0;
    cyc5();
    ackn5 = 1;
    cyc5();
    chk("d5 ack0 cnt", pend_cnt5, 4);
    chk("d5 ack0 ptr", pend_ptr5, 1);
    chk("d5 perr", par_err5, 0);

`ifdef STATUS_BUFFER_PARITY_EN
    rsn = 0; wrn = 1; ackn = 1;
    cyc();
    rsn = 1;
    a_ptr = 2'd0;
    force dut.r_par = 4'b0001;
    #1;
    chk("par raw", par_err, 1);
    cyc();
    release dut.r_par;
    a_ptr = 2'd1;
    #1;
    chk("par sticky", par_err, 1);
    cyc();
    chk("par sticky2", par_err, 1);
    rsn = 0;
    cyc();
    rsn = 1;
    #1;
    chk("par cleared", par_err, 0);
`else
    chk("par off", par_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
